// File: rtl/systolic_mm_array_pkg.sv
// Shared types and helpers for the systolic matrix multiplier.
//   state_t  : control FSM states (IDLE, LOAD, DRAIN, DONE)
//   DEF_*    : default operand / accumulator widths
//   lane_lo  : LSB of a lane inside a flattened bus
//   c_lane   : flattened index of C[i][j]
package mm_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 20;

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  function automatic int c_lane(input int i, input int j, input int n);
    return i * n + j;
  endfunction
endpackage

// File: rtl/systolic_mm_array_if.sv
// Beat-input / result-output bundle of the systolic multiplier.
//   master : job producer / result consumer side
//   slave  : the array itself
//   in_valid/in_ready/in_last/a_col/b_row : rank-1 beat stream
//   out_valid/out_ready/c_flat            : result handshake
//   busy/overflow                         : status
interface systolic_mm_array_if import mm_pkg::*; #(
  parameter int N      = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
);
  logic                   in_valid, in_ready, in_last;
  logic [N*DATA_W-1:0]    a_col, b_row;
  logic                   out_valid, out_ready;
  logic [N*N*ACC_W-1:0]   c_flat;
  logic                   busy, overflow;

  modport master (output in_valid, in_last, a_col, b_row, out_ready,
                  input  in_ready, out_valid, c_flat, busy, overflow);
  modport slave  (input  in_valid, in_last, a_col, b_row, out_ready,
                  output in_ready, out_valid, c_flat, busy, overflow);
endinterface

// File: rtl/systolic_mm_array_pe.sv
// systolic_pe: one output-stationary MAC cell.
//   a_in/b_in   : operands arriving from the left / above
//   a_out/b_out : registered copies forwarded right / down
//   en          : accumulate this cycle; clr: zero the accumulator (wins over en)
//   acc         : running C[i][j]; sat: the add of this cycle overflowed
// Macro SYSTOLIC_SAT_EN: clamp on signed overflow instead of wrapping.
module systolic_pe import mm_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     sat
);
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W:0]             sum;  // one guard bit exposes signed overflow
  logic [ACC_W-1:0]           nxt;

  assign prod = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);
  assign sum  = {acc[ACC_W-1], acc} + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};

`ifdef SYSTOLIC_SAT_EN
  always_comb begin
    nxt = sum[ACC_W-1:0];
    sat = 1'b0;
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat = 1'b1;
      nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign nxt = sum[ACC_W-1:0];
  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr)     acc <= '0;
      else if (en) acc <= nxt;
    end
  end
endmodule

// File: rtl/systolic_mm_array.sv
// systolic_mm_array: N x N output-stationary C = A*B, one rank-1 beat
// (column k of A, row k of B) per accepted handshake, any K >= 1.
//   clk, rst_n : clock, async active-low reset
//   bus        : systolic_mm_array_if.slave (beats in, C out, busy/overflow)
// Macro SYSTOLIC_SAT_EN: saturating accumulators with sticky overflow;
// otherwise accumulators wrap and overflow stays 0.
module systolic_mm_array import mm_pkg::*; #(
  parameter int N      = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_mm_array_if.slave   bus
);
  localparam int CW = $clog2(2*N);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept, busy, clr, ovf, sat_any;

  logic signed [DATA_W-1:0] a_h [N][N];   // A operand entering PE(i,j)
  logic signed [DATA_W-1:0] b_v [N][N];   // B operand entering PE(i,j)
  logic signed [ACC_W-1:0]  acc [N][N];
  logic                     sat [N][N];

  // Handshake and status come from registered state only.
  assign bus.in_ready  = (state == IDLE) || (state == LOAD);
  assign bus.out_valid = (state == DONE);
  assign busy          = (state == LOAD) || (state == DRAIN);
  assign bus.busy      = busy;
  assign bus.overflow  = ovf;
  assign accept        = bus.in_valid & bus.in_ready;
  assign clr           = bus.out_valid & bus.out_ready;

  // Input skew: stage 0 captures the beat (zero on bubbles), then lane i
  // sees i further delays so A[i][k] and B[k][j] meet at PE(i,j).
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic signed [DATA_W-1:0] sa [i+1];
    logic signed [DATA_W-1:0] sb [i+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d <= i; d++) begin
          sa[d] <= '0;
          sb[d] <= '0;
        end
      end else begin
        sa[0] <= accept ? bus.a_col[lane_lo(i, DATA_W) +: DATA_W] : '0;
        sb[0] <= accept ? bus.b_row[lane_lo(i, DATA_W) +: DATA_W] : '0;
        for (int d = 1; d <= i; d++) begin
          sa[d] <= sa[d-1];
          sb[d] <= sb[d-1];
        end
      end
    end
    assign a_h[i][0] = sa[i];
    assign b_v[0][i] = sb[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      logic signed [DATA_W-1:0] a_nx, b_nx;
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk, .rst_n, .en(busy), .clr,
        .a_in(a_h[i][j]), .b_in(b_v[i][j]),
        .a_out(a_nx), .b_out(b_nx),
        .acc(acc[i][j]), .sat(sat[i][j])
      );
      if (j < N-1) begin : g_right
        assign a_h[i][j+1] = a_nx;
      end
      if (i < N-1) begin : g_down
        assign b_v[i+1][j] = b_nx;
      end
    end
  end

  always_comb begin
    bus.c_flat = '0;
    sat_any    = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        bus.c_flat[c_lane(i, j, N)*ACC_W +: ACC_W] = acc[i][j];
        sat_any = sat_any | sat[i][j];
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == DRAIN) ? cnt + CW'(1) : '0;
      if (clr)                  ovf <= 1'b0;
      else if (busy && sat_any) ovf <= 1'b1;
    end
  end

  // Drain spans 2N cycles so the corner PE's last accumulate
  // (2N-1 edges after the final beat) lands before DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.in_last ? DRAIN : LOAD;
      LOAD:    if (accept && bus.in_last) state_nxt = DRAIN;
      DRAIN:   if (cnt == CW'(2*N-1)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_systolic_mm_array.sv
`timescale 1ns/1ps
module tb_systolic_mm_array;
  localparam int N = 2, DW = 8, AW = 20, AW16 = 16, BW = N*DW;
  typedef logic [BW-1:0] beat_t;
  typedef struct {
    int     k;
    int     gap;
    beat_t  a [3];
    beat_t  b [3];
    longint c [N*N];
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_mm_array_if #(.N(N), .DATA_W(DW), .ACC_W(AW))   bus();
  systolic_mm_array_if #(.N(N), .DATA_W(DW), .ACC_W(AW16)) bus16();

  systolic_mm_array #(.N(N), .DATA_W(DW), .ACC_W(AW))   u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  systolic_mm_array #(.N(N), .DATA_W(DW), .ACC_W(AW16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int     total = 0, bad = 0;
  int     lat;
  longint exp_c [N*N];
  bit     exp_ovf;
  vec_t   tbl [4];
  beat_t  qa[$], qb[$];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic longint c_of(input int idx);
    logic signed [AW-1:0] v;
    v = bus.c_flat[idx*AW +: AW];
    return longint'(v);
  endfunction

  function automatic longint c16_of(input int idx);
    logic signed [AW16-1:0] v;
    v = bus16.c_flat[idx*AW16 +: AW16];
    return longint'(v);
  endfunction

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], applied in k order with
  // either clamping or modular wrap at aw bits.
  task automatic model(input int aw);
    longint lim = longint'(1) << (aw - 1);
    exp_ovf = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int k = 0; k < qa.size(); k++) begin
          logic signed [DW-1:0] av, bv;
          av = qa[k][i*DW +: DW];
          bv = qb[k][j*DW +: DW];
          s += longint'(av) * longint'(bv);
`ifdef SYSTOLIC_SAT_EN
          if (s > lim - 1) begin s = lim - 1; exp_ovf = 1'b1; end
          else if (s < -lim) begin s = -lim; exp_ovf = 1'b1; end
`else
          s = ((s % (2*lim)) + 3*lim) % (2*lim) - lim;
`endif
        end
        exp_c[i*N+j] = s;
      end
  endtask

  task automatic send_job(input int gap);
    for (int k = 0; k < qa.size(); k++) begin
      int t = 0;
      bus.in_valid = 1'b1; bus.a_col = qa[k]; bus.b_row = qb[k];
      bus.in_last  = (k == qa.size() - 1);
      while (!bus.in_ready && t < 64) begin @(posedge clk); #1; t++; end
      if (t >= 64) chk("in_ready_wait", 0, 1);
      @(posedge clk); #1;
      // Idle-cycle garbage must not leak into the array.
      bus.in_valid = 1'b0; bus.in_last = 1'($urandom_range(0, 1));
      bus.a_col = beat_t'($urandom); bus.b_row = beat_t'($urandom);
      if (k != qa.size() - 1)
        for (int g = 0; g < gap; g++) begin
          chk("busy_gap", longint'(bus.busy), 1);
          @(posedge clk); #1;
        end
    end
  endtask

  task automatic wait_out();
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      chk("busy_drain", longint'(bus.busy), 1);
      chk("ready_drain", longint'(bus.in_ready), 0);
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) chk("out_valid_wait", 0, 1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_ready", longint'(bus.in_ready), 1);
    chk("idle_out_valid", longint'(bus.out_valid), 0);
    chk("idle_busy", longint'(bus.busy), 0);
  endtask

  task automatic load_vec(input int t);
    qa.delete(); qb.delete();
    for (int k = 0; k < tbl[t].k; k++) begin qa.push_back(tbl[t].a[k]); qb.push_back(tbl[t].b[k]); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.in_last = 0; bus.a_col = '0; bus.b_row = '0; bus.out_ready = 0;
    bus16.in_valid = 0; bus16.in_last = 0; bus16.a_col = '0; bus16.b_row = '0; bus16.out_ready = 0;

    tbl[0] = '{2, 0, '{16'h0301, 16'h0402, 16'h0000}, '{16'h0605, 16'h0807, 16'h0000}, '{19, 22, 43, 50}};
    tbl[1] = '{2, 0, '{16'hFF80, 16'h007F, 16'h0000}, '{16'h0180, 16'hFF7F, 16'h0000}, '{32513, -255, 128, -1}};
    tbl[2] = '{2, 3, '{16'h0301, 16'h0402, 16'h0000}, '{16'h0605, 16'h0807, 16'h0000}, '{19, 22, 43, 50}};
    tbl[3] = '{1, 0, '{16'h0302, 16'h0000, 16'h0000}, '{16'h0504, 16'h0000, 16'h0000}, '{8, 10, 12, 15}};

    // Reset state
    #1;
    for (int i = 0; i < N*N; i++) chk("rst_c", c_of(i), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_ovf", longint'(bus.overflow), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", longint'(bus.in_ready), 1);

    // Directed table: basic, signed extremes, bubbles, K=1
    for (int t = 0; t < 4; t++) begin
      load_vec(t);
      send_job(tbl[t].gap);
      wait_out();
      chk("latency", lat, 2*N);
      for (int i = 0; i < N*N; i++) chk("tbl_c", c_of(i), tbl[t].c[i]);
      chk("tbl_ovf", longint'(bus.overflow), 0);
      consume();
    end

    // Backpressure in DONE, with in_valid asserted and ignored
    load_vec(0);
    send_job(0);
    wait_out();
    bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.a_col = 16'h7F7F; bus.b_row = 16'h7F7F;
    for (int c = 0; c < 10; c++) begin
      chk("bp_out_valid", longint'(bus.out_valid), 1);
      chk("bp_ready", longint'(bus.in_ready), 0);
      for (int i = 0; i < N*N; i++) chk("bp_c", c_of(i), tbl[0].c[i]);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    consume();
    for (int i = 0; i < N*N; i++) chk("bp_clr_c", c_of(i), 0);
    load_vec(3);
    send_job(0);
    wait_out();
    for (int i = 0; i < N*N; i++) chk("bp_k1_c", c_of(i), tbl[3].c[i]);
    consume();

    // Reset in the middle of a job
    bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.a_col = tbl[0].a[0]; bus.b_row = tbl[0].b[0];
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_c00", c_of(0), 5);
    chk("pre_rst_c01", c_of(1), 0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N*N; i++) chk("midrst_c", c_of(i), 0);
    chk("midrst_busy", longint'(bus.busy), 0);
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_ready", longint'(bus.in_ready), 1);
    load_vec(0);
    send_job(0);
    wait_out();
    for (int i = 0; i < N*N; i++) chk("rerun_c", c_of(i), tbl[0].c[i]);
    consume();

    // 16-bit accumulators: three beats of 127*127
    begin
      int t = 0;
      bus16.in_valid = 1'b1; bus16.a_col = 16'h7F7F; bus16.b_row = 16'h7F7F;
      for (int k = 0; k < 3; k++) begin
        bus16.in_last = (k == 2);
        @(posedge clk); #1;
      end
      bus16.in_valid = 1'b0; bus16.in_last = 1'b0;
      while (!bus16.out_valid && t < 100) begin @(posedge clk); #1; t++; end
      chk("acc16_latency", t, 2*N);
      for (int i = 0; i < N*N; i++) begin
`ifdef SYSTOLIC_SAT_EN
        chk("acc16_c", c16_of(i), 32767);
`else
        chk("acc16_c", c16_of(i), -17149);
`endif
      end
`ifdef SYSTOLIC_SAT_EN
      chk("acc16_ovf", longint'(bus16.overflow), 1);
`else
      chk("acc16_ovf", longint'(bus16.overflow), 0);
`endif
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
      chk("acc16_ovf_clr", longint'(bus16.overflow), 0);
      chk("acc16_c_clr", c16_of(0), 0);
    end

    // Random jobs against the reference model
    for (int r = 0; r < 25; r++) begin
      int kk = $urandom_range(1, 6);
      int hold = $urandom_range(0, 3);
      qa.delete(); qb.delete();
      for (int k = 0; k < kk; k++) begin qa.push_back(beat_t'($urandom)); qb.push_back(beat_t'($urandom)); end
      model(AW);
      send_job($urandom_range(0, 2));
      wait_out();
      chk("rnd_latency", lat, 2*N);
      for (int h = 0; h <= hold; h++) begin
        for (int i = 0; i < N*N; i++) chk("rnd_c", c_of(i), exp_c[i]);
        chk("rnd_ovf", longint'(bus.overflow), longint'(exp_ovf));
        if (h < hold) begin @(posedge clk); #1; end
      end
      consume();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
